// File: rtl/instr_loader_if.sv
// Bus bundle for instr_loader: source word stream in, instruction-memory writes out.
// The loader takes the master modport because it masters the memory write.
interface instr_loader_if #(
  parameter int INSTR_W      = 32,
  parameter int INSTR_ADDR_W = 10
);
  logic                    in_valid;
  logic [INSTR_W-1:0]      in_data;
  logic                    in_ready;
  logic                    mem_wr_en;
  logic [INSTR_ADDR_W-1:0] mem_wr_addr;
  logic [INSTR_W-1:0]      mem_wr_data;
  logic                    mem_wr_ack;

  modport master (
    input  in_valid, in_data, mem_wr_ack,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output in_valid, in_data, mem_wr_ack,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/instr_loader.sv
// Streams an instruction image into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word and report mismatches on err.
module instr_loader #(
  parameter int INSTR_W      = 32,
  parameter int INSTR_ADDR_W = 10,
  parameter int NUM_INSTRS   = 1024
) (
  input  logic           sys_clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  instr_loader_if.master bus,
  output logic           cpu_reset_n,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam logic [INSTR_ADDR_W-1:0] LAST_ADDR = INSTR_ADDR_W'(NUM_INSTRS - 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, CHECK, DONE} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [INSTR_ADDR_W-1:0] addr;
  logic [INSTR_W-1:0]      wr_data;
  logic                    abort_pending;
  logic                    in_ready;
  logic                    wr_en;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Abort during a write is remembered so the outstanding write still completes.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state == DONE);
        if (abort)      next_state = IDLE;
        else if (start) next_state = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (abort)             next_state = IDLE;
        else if (bus.in_valid) next_state = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (bus.mem_wr_ack) begin
          if (abort || abort_pending) next_state = IDLE;
`ifdef LOADER_CHECKSUM_EN
          else if (addr == LAST_ADDR) next_state = CHECK;
`else
          else if (addr == LAST_ADDR) next_state = DONE;
`endif
          else                        next_state = ACCEPT;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (abort)             next_state = IDLE;
        else if (bus.in_valid) next_state = DONE;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= '0;
      wr_data       <= '0;
      abort_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) addr <= '0;
        end
        ACCEPT: begin
          if (bus.in_valid && !abort) wr_data <= bus.in_data;
        end
        WRITE: begin
          if (bus.mem_wr_ack) begin
            abort_pending <= 1'b0;
            if (!(abort || abort_pending) && addr != LAST_ADDR) addr <= addr + 1'b1;
          end else if (abort) begin
            abort_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] checksum;
  logic               err_q;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            checksum <= '0;
            err_q    <= 1'b0;
          end
        end
        ACCEPT: begin
          if (bus.in_valid && !abort) checksum <= checksum + bus.in_data;
        end
        CHECK: begin
          if (bus.in_valid && !abort) err_q <= (bus.in_data != checksum);
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = addr;
  assign bus.mem_wr_data = wr_data;
  assign cpu_reset_n     = ~busy;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: queue-driven source, configurable-latency memory,
// and a write log compared against the image that was offered.
module tb_instr_loader;
  localparam int INSTR_W      = 32;
  localparam int INSTR_ADDR_W = 4;
  localparam int NUM_INSTRS   = 4;
  localparam int TIMEOUT      = 400;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  typedef struct {
    logic [INSTR_ADDR_W-1:0] addr;
    logic [INSTR_W-1:0]      data;
  } wr_t;

  logic sys_clock = 1'b0;
  logic reset_n   = 1'b0;
  logic start     = 1'b0;
  logic abort     = 1'b0;
  logic cpu_reset_n, busy, done, err;

  int checks    = 0;
  int errors    = 0;
  int viol      = 0;
  int ack_delay = 0;
  int ack_cnt   = 0;
  bit ack_noise = 1'b0;
  bit take      = 1'b0;

  logic [INSTR_W-1:0] img [NUM_INSTRS];
  logic [INSTR_W-1:0] src_q [$];
  logic [INSTR_W-1:0] exp_d [$];
  wr_t                wlog [$];

  instr_loader_if #(.INSTR_W(INSTR_W), .INSTR_ADDR_W(INSTR_ADDR_W)) bus ();

  instr_loader #(
    .INSTR_W(INSTR_W), .INSTR_ADDR_W(INSTR_ADDR_W), .NUM_INSTRS(NUM_INSTRS)
  ) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .start(start), .abort(abort),
    .bus(bus), .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clock = ~sys_clock;

  // Source keeps offering the head of src_q every cycle; a word leaves only on a real handshake.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge sys_clock);
      take = reset_n && bus.in_valid && bus.in_ready;
      @(posedge sys_clock);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      bus.in_valid = (src_q.size() > 0);
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : INSTR_W'($urandom);
    end
  end

  // Memory acks after ack_delay extra cycles; optional random ack noise while idle.
  initial begin
    bus.mem_wr_ack = 1'b0;
    forever begin
      @(posedge sys_clock);
      #1;
      if (bus.mem_wr_en) begin
        if (ack_cnt >= ack_delay) begin
          bus.mem_wr_ack = 1'b1;
          ack_cnt = 0;
        end else begin
          bus.mem_wr_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
        bus.mem_wr_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  always @(negedge sys_clock) begin
    if (reset_n && bus.mem_wr_en && bus.mem_wr_ack)
      wlog.push_back('{addr: bus.mem_wr_addr, data: bus.mem_wr_data});
    if (busy === cpu_reset_n) viol++;
    if (bus.mem_wr_en && (!busy || bus.in_ready)) viol++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      tick();
      ok = (done === 1'b1);
    end
  endtask

  task automatic rand_img();
    for (int i = 0; i < NUM_INSTRS; i++) img[i] = INSTR_W'($urandom);
  endtask

  // Offers img; with the checksum build a trailer of sum+trailer_mode follows, otherwise a stray extra word.
  task automatic push_image(input int trailer_mode);
    logic [INSTR_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_INSTRS; i++) begin
      src_q.push_back(img[i]);
      exp_d.push_back(img[i]);
      sum = sum + img[i];
    end
`ifdef LOADER_CHECKSUM_EN
    src_q.push_back(sum + INSTR_W'(trailer_mode));
`else
    if (trailer_mode != 0) src_q.push_back(sum);
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    checks++;
    if ({bus.in_ready, bus.mem_wr_en, busy, done, err, cpu_reset_n} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 000001",
               {bus.in_ready, bus.mem_wr_en, busy, done, err, cpu_reset_n});
    end
    checks++;
    if (bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr %0d data %h, expected 0 0", bus.mem_wr_addr, bus.mem_wr_data);
    end
    reset_n = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy %b done %b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int cyc, cpu_hi;
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    wlog.delete(); exp_d.delete();
    ack_delay = 0; ack_noise = 1'b0;
    push_image(0);
    tick(2);
    start = 1'b1;
    cyc = 0; cpu_hi = 0; ok = 1'b0;
    while (!ok && cyc < TIMEOUT) begin
      tick();
      start = 1'b0;
      cyc++;
      ok = (done === 1'b1);
      if (!ok && cpu_reset_n !== 1'b0) cpu_hi++;
    end
    checks++;
    if (!ok || cyc != 2 * NUM_INSTRS + 1 + CHK_EXTRA) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d cycles, expected %0d", cyc, 2 * NUM_INSTRS + 1 + CHK_EXTRA);
    end
    checks++;
    if (cpu_hi != 0) begin
      errors++;
      $display("[TB] FAIL basic_cpu_reset: got %0d cycles with cpu_reset_n high, expected 0", cpu_hi);
    end
    checks++;
    if (wlog.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL basic_writes: got %0d writes, expected %0d", wlog.size(), exp_d.size());
    end
    for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
      checks++;
      if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL basic_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
      end
    end
    checks++;
    if (cpu_reset_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release: got cpu_reset_n %b busy %b, expected 1 0", cpu_reset_n, busy);
    end
  endtask

  task automatic test_ack_delay();
    bit ok, prev_en;
    int run, bad_run, stab_err;
    logic [INSTR_ADDR_W-1:0] p_addr;
    logic [INSTR_W-1:0]      p_data;
    rand_img();
    wlog.delete(); exp_d.delete();
    ack_delay = 5;
    push_image(0);
    tick(2);
    pulse_start();
    ok = 1'b0; prev_en = 1'b0; run = 0; bad_run = 0; stab_err = 0; p_addr = '0; p_data = '0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      if (bus.mem_wr_en === 1'b1) begin
        if (prev_en && (bus.mem_wr_addr !== p_addr || bus.mem_wr_data !== p_data)) stab_err++;
        if (bus.in_ready !== 1'b0) stab_err++;
        run++;
      end else if (prev_en) begin
        if (run != ack_delay + 1) bad_run++;
        run = 0;
      end
      prev_en = bus.mem_wr_en;
      p_addr  = bus.mem_wr_addr;
      p_data  = bus.mem_wr_data;
      ok = (done === 1'b1);
      if (!ok) tick();
    end
    checks++;
    if (!ok || stab_err != 0 || bad_run != 0) begin
      errors++;
      $display("[TB] FAIL delay_hold: got done %b unstable %0d bad_runs %0d, expected 1 0 0", ok, stab_err, bad_run);
    end
    checks++;
    if (wlog.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL delay_writes: got %0d writes, expected %0d", wlog.size(), exp_d.size());
    end
    for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
      checks++;
      if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL delay_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      rand_img();
      wlog.delete(); exp_d.delete();
      viol = 0;
      ack_delay = $urandom_range(0, 3);
      ack_noise = 1'b1;
      push_image(0);
      tick(2);
      pulse_start();
      wait_done(ok);
      checks++;
      if (!ok || viol != 0) begin
        errors++;
        $display("[TB] FAIL random_run[%0d]: got done %b violations %0d, expected 1 0", it, ok, viol);
      end
      checks++;
      if (wlog.size() != exp_d.size()) begin
        errors++;
        $display("[TB] FAIL random_writes[%0d]: got %0d writes, expected %0d", it, wlog.size(), exp_d.size());
      end
      for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
        checks++;
        if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
          errors++;
          $display("[TB] FAIL random_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                   i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
        end
      end
    end
    ack_noise = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_abort();
    bit found, idle;
    rand_img();
    wlog.delete(); exp_d.delete();
    ack_delay = 3;
    push_image(0);
    while (exp_d.size() > 2) void'(exp_d.pop_back());
    tick(2);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < TIMEOUT && !found; i++) begin
      if (bus.mem_wr_en === 1'b1 && bus.mem_wr_addr === INSTR_ADDR_W'(1)) found = 1'b1;
      else tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    src_q.delete();
    idle = 1'b0;
    for (int i = 0; i < TIMEOUT && !idle; i++) begin
      tick();
      idle = (busy === 1'b0);
    end
    tick(4);
    checks++;
    if (!found || !idle || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: got found %b idle %b busy %b done %b, expected 1 1 0 0", found, idle, busy, done);
    end
    checks++;
    if (wlog.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL abort_writes: got %0d writes, expected %0d", wlog.size(), exp_d.size());
    end
    for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
      checks++;
      if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL abort_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_abort_accept();
    src_q.delete();
    tick(2);
    pulse_start();
    tick(2);
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_wait: got busy %b in_ready %b, expected 1 1", busy, bus.in_ready);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_abort: got busy %b in_ready %b done %b, expected 0 0 0", busy, bus.in_ready, done);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_reset_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_beats_start: got busy %b cpu_reset_n %b, expected 0 1", busy, cpu_reset_n);
    end
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    rand_img();
    wlog.delete(); exp_d.delete();
    src_q.push_back(img[0]);
    src_q.push_back(img[1]);
    tick(2);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < TIMEOUT && !found; i++) begin
      if (bus.in_ready === 1'b1 && bus.mem_wr_addr === INSTR_ADDR_W'(2)) found = 1'b1;
      else tick();
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (!found || {bus.in_ready, bus.mem_wr_en, busy, done, err, cpu_reset_n} !== 6'b000001 ||
        bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got found %b ctrl %b addr %0d data %h, expected 1 000001 0 0", found,
               {bus.in_ready, bus.mem_wr_en, busy, done, err, cpu_reset_n}, bus.mem_wr_addr, bus.mem_wr_data);
    end
    #1 reset_n = 1'b1;
    tick();
    wlog.delete(); exp_d.delete();
    rand_img();
    push_image(0);
    tick(2);
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok || wlog.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL reset_reload: got done %b writes %0d, expected 1 %0d", ok, wlog.size(), exp_d.size());
    end
    for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
      checks++;
      if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL reset_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    wlog.delete(); exp_d.delete();
    rand_img();
    push_image(0);
    rand_img();
    push_image(0);
    tick(2);
    start = 1'b1;
    wait_done(ok1);
    tick();
    checks++;
    if (!ok1 || busy !== 1'b1 || done !== 1'b0 || bus.mem_wr_addr !== '0) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got done_seen %b busy %b done %b addr %0d, expected 1 1 0 0",
               ok1, busy, done, bus.mem_wr_addr);
    end
    tick(3);
    start = 1'b0;
    wait_done(ok2);
    tick(3);
    checks++;
    if (!ok2 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got done_seen %b done %b busy %b, expected 1 1 0", ok2, done, busy);
    end
    checks++;
    if (wlog.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL b2b_writes: got %0d writes, expected %0d", wlog.size(), exp_d.size());
    end
    for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
      checks++;
      if (wlog[i].addr !== INSTR_ADDR_W'(i % NUM_INSTRS) || wlog[i].data !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL b2b_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wlog[i].addr, wlog[i].data, i % NUM_INSTRS, exp_d[i]);
      end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    img[0] = 32'h1; img[1] = 32'h2; img[2] = 32'h3; img[3] = 32'h4;
    wlog.delete(); exp_d.delete();
    src_q.delete();
`ifdef LOADER_CHECKSUM_EN
    push_image(0);
    tick(2);
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL checksum_good: got done %b err %b, expected 1 0", ok, err);
    end
    push_image(1);
    tick(2);
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok || err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL checksum_bad: got done %b err %b, expected 1 1", ok, err);
    end
`else
    push_image(1);
    tick(2);
    pulse_start();
    wait_done(ok);
    tick(3);
    checks++;
    if (!ok || err !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nochecksum_done: got done %b err %b, expected 1 0", ok, err);
    end
    checks++;
    if (src_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL nochecksum_extra: got %0d words left, expected 1", src_q.size());
    end
    src_q.delete();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_random();
    test_abort();
    test_abort_accept();
    test_reset_mid();
    test_back_to_back();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
